iir_lowpass_mc_filter: RTL and testbench

Multi-channel, time-multiplexed cascade of first-order IIR low-pass stages with k = 2^shift, chosen per sample at run time. One shared update datapath serves all CHANNELS × FILTER_STAGES states, so many sensor channels are smoothed for the cost of one. It adds several things a fixed-shift, single-channel filter lacks: a valid/ready input handshake, a channel-tagged output, optional rounding, and a PRIME mode for instant settling. It sits between the per-channel period/phase measurement and the pitch/volume mapping logic.

---
 rtl/iir_filter_pkg.sv | 18 +
 rtl/iir_pow2_update.sv | 34 +++
 rtl/iir_lowpass_mc_filter.sv | 149 ++++++++++++++
 tb/tb_iir_lowpass_mc_filter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_filter_pkg.sv
// Shared types and helpers for the time-multiplexed IIR low-pass filter.
package iir_filter_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } iir_state_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned clamp_shift(input int unsigned shift,
                                              input int unsigned max_shift);
    return (shift > max_shift) ? max_shift : shift;
  endfunction

endpackage

// File: rtl/iir_pow2_update.sv
// One first-order low-pass step: st + ((in - st) >>> s), with optional
// half-up rounding and a prime bypass that loads the input directly.
module iir_pow2_update #(
  parameter int ACC         = 45,
  parameter int S_W         = 4,
  parameter int SIGNED_DATA = 1,
  parameter int ROUNDING    = 1
) (
  input  logic [ACC-1:0] in_value,
  input  logic [ACC-1:0] st,
  input  logic [S_W-1:0] shift,
  input  logic           prime,
  output logic [ACC-1:0] st_new
);

  logic signed [ACC:0] in_x;
  logic signed [ACC:0] st_x;
  logic signed [ACC:0] rnd;
  logic signed [ACC:0] d;
  logic signed [ACC:0] d_sh;

  always_comb begin
    in_x = (SIGNED_DATA != 0) ? {in_value[ACC-1], in_value} : {1'b0, in_value};
    st_x = (SIGNED_DATA != 0) ? {st[ACC-1], st} : {1'b0, st};
    rnd  = '0;
    if (ROUNDING != 0 && shift != '0) begin
      rnd = (ACC+1)'(1) << (shift - S_W'(1));
    end
    d      = in_x - st_x + rnd;
    d_sh   = d >>> shift;
    st_new = prime ? in_value : ACC'(st_x + d_sh);
  end

endmodule

// File: rtl/iir_lowpass_mc_filter.sv
// Multi-channel cascade of first-order IIR low-pass stages sharing one update
// datapath; each accepted sample walks its channel's stages one per CE cycle.
module iir_lowpass_mc_filter
  import iir_filter_pkg::*;
#(
  parameter int INPUT_BITS    = 30,
  parameter int RESULT_BITS   = 30,
  parameter int MAX_SHIFT     = 15,
  parameter int SHIFT_W       = 4,
  parameter int CHANNELS      = 4,
  parameter int FILTER_STAGES = 2,
  parameter int SIGNED_DATA   = 1,
  parameter int ROUNDING      = 1,
  localparam int CH_W         = ch_width(CHANNELS)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CE,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [CH_W-1:0]        IN_CHANNEL,
  input  logic [INPUT_BITS-1:0]  IN_VALUE,
  input  logic                   IN_PRIME,
  input  logic [SHIFT_W-1:0]     SHIFT,
  output logic                   OUT_VALID,
  output logic [CH_W-1:0]        OUT_CHANNEL,
  output logic [RESULT_BITS-1:0] OUT_VALUE
);

  localparam int ACC   = RESULT_BITS + MAX_SHIFT;
  localparam int S_W   = $clog2(MAX_SHIFT + 1);
  localparam int STG_W = ch_width(FILTER_STAGES);

  iir_state_e state_q, state_d;
  logic accept, last;

  logic [ACC-1:0]         st_mem [CHANNELS][FILTER_STAGES];
  logic [STG_W-1:0]       stg_q;
  logic [CH_W-1:0]        ch_q;
  logic [ACC-1:0]         x_q;
  logic                   prime_q;
  logic [S_W-1:0]         shift_q;
  logic [ACC-1:0]         carry_q;
  logic                   out_valid_q;
  logic [CH_W-1:0]        out_channel_q;
  logic [RESULT_BITS-1:0] out_value_q;

  logic           ch_ok;
  logic [CH_W-1:0] rd_ch;
  logic [ACC-1:0] st_rd, stage_in, st_new;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else if (CE) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stg_q == STG_W'(FILTER_STAGES - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range channels still run the stage sequence but read a harmless
  // entry and never write, so they keep the normal timing.
  always_comb begin
    ch_ok    = 32'(ch_q) < CHANNELS;
    rd_ch    = ch_ok ? ch_q : '0;
    st_rd    = st_mem[rd_ch][stg_q];
    stage_in = (stg_q == '0) ? x_q : carry_q;
  end

  iir_pow2_update #(
    .ACC         (ACC),
    .S_W         (S_W),
    .SIGNED_DATA (SIGNED_DATA),
    .ROUNDING    (ROUNDING)
  ) u_update (
    .in_value (stage_in),
    .st       (st_rd),
    .shift    (shift_q),
    .prime    (prime_q),
    .st_new   (st_new)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned s = 0; s < FILTER_STAGES; s++) begin
          st_mem[c][s] <= '0;
        end
      end
      stg_q         <= '0;
      ch_q          <= '0;
      x_q           <= '0;
      prime_q       <= 1'b0;
      shift_q       <= '0;
      carry_q       <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_value_q   <= '0;
    end else if (CE) begin
      out_valid_q <= 1'b0;
      if (accept) begin
        ch_q    <= IN_CHANNEL;
        x_q     <= ACC'(IN_VALUE) << (ACC - INPUT_BITS);
        prime_q <= IN_PRIME;
        shift_q <= S_W'(clamp_shift(32'(SHIFT), MAX_SHIFT));
        stg_q   <= '0;
      end
      if (state_q == RUN) begin
        if (ch_ok) begin
          st_mem[ch_q][stg_q] <= st_new;
        end
        // Next stage sees only the integer part of the value just written.
        carry_q <= {st_new[ACC-1:MAX_SHIFT], {MAX_SHIFT{1'b0}}};
        stg_q   <= stg_q + 1'b1;
        if (last && ch_ok) begin
          out_valid_q   <= 1'b1;
          out_channel_q <= ch_q;
          out_value_q   <= st_new[ACC-1:MAX_SHIFT];
        end
      end
    end
  end

  assign IN_READY    = (state_q == IDLE);
  assign OUT_VALID   = out_valid_q;
  assign OUT_CHANNEL = out_channel_q;
  assign OUT_VALUE   = out_value_q;

endmodule

// File: tb/tb_iir_lowpass_mc_filter.sv
// Scoreboard bench: a signed/truncating and an unsigned/rounding instance share
// stimulus; an arithmetic reference model predicts each channel-tagged result.
module tb_iir_lowpass_mc_filter;

  localparam int RB  = 16;
  localparam int IB  = 16;
  localparam int MS  = 4;
  localparam int SW  = 4;
  localparam int NCH = 5;  // 3-bit channel tag, so channel 5 is out of range
  localparam int NST = 2;
  localparam int CHW = 3;
  localparam int ACC = RB + MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic in_valid = 1'b0;
  logic in_prime = 1'b0;
  logic [CHW-1:0] in_ch = '0;
  logic [IB-1:0]  in_val = '0;
  logic [SW-1:0]  shift = '0;

  logic rdy0, rdy1, ov0, ov1;
  logic [CHW-1:0] och0, och1;
  logic [RB-1:0]  oval0, oval1;

  iir_lowpass_mc_filter #(
    .INPUT_BITS(IB), .RESULT_BITS(RB), .MAX_SHIFT(MS), .SHIFT_W(SW),
    .CHANNELS(NCH), .FILTER_STAGES(NST), .SIGNED_DATA(1), .ROUNDING(0)
  ) dut (
    .CLK(clk), .RESET(rst), .CE(ce), .IN_VALID(in_valid), .IN_READY(rdy0),
    .IN_CHANNEL(in_ch), .IN_VALUE(in_val), .IN_PRIME(in_prime), .SHIFT(shift),
    .OUT_VALID(ov0), .OUT_CHANNEL(och0), .OUT_VALUE(oval0)
  );

  iir_lowpass_mc_filter #(
    .INPUT_BITS(IB), .RESULT_BITS(RB), .MAX_SHIFT(MS), .SHIFT_W(SW),
    .CHANNELS(NCH), .FILTER_STAGES(NST), .SIGNED_DATA(0), .ROUNDING(1)
  ) dut_u (
    .CLK(clk), .RESET(rst), .CE(ce), .IN_VALID(in_valid), .IN_READY(rdy1),
    .IN_CHANNEL(in_ch), .IN_VALUE(in_val), .IN_PRIME(in_prime), .SHIFT(shift),
    .OUT_VALID(ov1), .OUT_CHANNEL(och1), .OUT_VALUE(oval1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     ch;
    longint val;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   e_m;
  longint mst[2][NCH][NST];
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_out0 = 0;
  int     out_cyc0 = 0;
  int     acc_cyc = 0;
  bit     ce_rand = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic longint u16(input int v);
    return longint'(v & 'hFFFF);
  endfunction

  function automatic longint wrap(input longint v, input bit sgn);
    longint r;
    r = v & ((longint'(1) << ACC) - 1);
    if (sgn && r >= (longint'(1) << (ACC - 1))) r = r - (longint'(1) << ACC);
    return r;
  endfunction

  // Instance k: 0 = signed/truncate, 1 = unsigned/round half-up.
  function automatic void model(input int k, input int ch, input logic [IB-1:0] v,
                                input bit prime, input int sh);
    bit     sgn;
    bit     rnd;
    int     s;
    longint inp;
    longint d;
    exp_t   e;
    sgn = (k == 0);
    rnd = (k == 1);
    s   = (sh > MS) ? MS : sh;
    if (ch >= NCH) return;
    inp = sgn ? longint'($signed(v)) : longint'(v);
    inp = wrap(inp * (longint'(1) << MS), sgn);
    for (int i = 0; i < NST; i++) begin
      if (prime) begin
        mst[k][ch][i] = inp;
      end else begin
        d = inp - mst[k][ch][i];
        if (rnd && s > 0) d = d + (longint'(1) << (s - 1));
        mst[k][ch][i] = wrap(mst[k][ch][i] + (d >>> s), sgn);
      end
      inp = (mst[k][ch][i] >>> MS) * (longint'(1) << MS);
    end
    e.ch  = ch;
    e.val = (mst[k][ch][NST-1] >>> MS) & 'hFFFF;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && ce) begin
      if (ov0) begin
        n_out0++;
        out_cyc0 = cyc;
        if (q0.size() == 0) fail("spurious_out0", "got OUT_VALID, expected none");
        else begin
          e_m = q0.pop_front();
          chk("out_ch0", longint'(och0), e_m.ch);
          chk("out_val0", longint'(oval0), e_m.val);
        end
      end
      if (ov1) begin
        if (q1.size() == 0) fail("spurious_out1", "got OUT_VALID, expected none");
        else begin
          e_m = q1.pop_front();
          chk("out_ch1", longint'(och1), e_m.ch);
          chk("out_val1", longint'(oval1), e_m.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ce_rand) ce = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < NST; i++) mst[k][c][i] = 0;
    chk("rst_ready", longint'(rdy0), 1);
    chk("rst_out_valid", longint'(ov0), 0);
    chk("rst_out_value", longint'(oval0), 0);
    chk("rst_out_channel", longint'(och0), 0);
  endtask

  task automatic send(input int ch, input int v, input bit prime, input int sh);
    int n;
    n        = 0;
    in_ch    = CHW'(ch);
    in_val   = IB'(v);
    in_prime = prime;
    shift    = SW'(sh);
    in_valid = 1'b1;
    while (!(rdy0 && ce) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail("send_timeout", "no IN_READY within 200 cycles, required acceptance");
    chk("ready_match", longint'(rdy1), longint'(rdy0));
    model(0, ch, in_val, prime, sh);
    model(1, ch, in_val, prime, sh);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || !rdy0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) fail("drain_timeout", "results pending after 300 cycles, required none");
  endtask

  initial begin
    int     prev_n;
    longint prev_v;
    longint prev_c;
    int     n_acc;
    int     acc_c[4];

    do_reset();

    // Step response and handshake timing.
    send(0, 1000, 0, 1);
    chk("ready_low_t0", longint'(rdy0), 0);
    tick();
    chk("ready_low_t1", longint'(rdy0), 0);
    chk("no_early_valid", longint'(ov0), 0);
    tick();
    chk("valid_at_t2", longint'(ov0), 1);
    chk("ready_back_t2", longint'(rdy0), 1);
    wait_done();
    chk("latency", out_cyc0 - acc_cyc, NST);
    chk("step_first", longint'(oval0), 250);
    send(0, 1000, 0, 1);
    wait_done();
    chk("step_second", longint'(oval0), 500);

    send(1, 1234, 0, 0);
    wait_done();
    chk("passthrough", longint'(oval0), 1234);

    send(3, 1600, 0, 9);
    wait_done();
    chk("shift_clamp", longint'(oval0), 6);

    send(2, -300, 1, 0);
    wait_done();
    chk("prime_neg", longint'(oval0), u16(-300));
    send(2, -300, 0, 4);
    wait_done();
    chk("primed_settled", longint'(oval0), u16(-300));

    send(2, 800, 0, 2);
    wait_done();
    send(1, 1234, 0, 3);
    wait_done();
    chk("ch1_isolated", longint'(oval0), 1234);

    send(0, 'hFFFF, 1, 3);
    wait_done();
    chk("prime_unsigned", longint'(oval1), 'hFFFF);
    send(0, 0, 0, 1);
    wait_done();
    chk("unsigned_decay", longint'(oval1), 49151);

    // IN_VALID held high: accepts only when the block returns to IDLE.
    in_ch    = CHW'(3);
    in_val   = IB'(777);
    in_prime = 1'b0;
    shift    = SW'(2);
    in_valid = 1'b1;
    n_acc    = 0;
    for (int i = 0; i < 9; i++) begin
      if (rdy0 && ce) begin
        model(0, 3, in_val, 1'b0, 2);
        model(1, 3, in_val, 1'b0, 2);
        if (n_acc < 4) acc_c[n_acc] = cyc + 1;
        n_acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    wait_done();
    chk("hold_accepts", n_acc, 3);
    chk("hold_gap1", acc_c[1] - acc_c[0], NST + 1);
    chk("hold_gap2", acc_c[2] - acc_c[1], NST + 1);

    send(4, 500, 0, 2);
    tick();
    ce = 1'b0;
    repeat (5) tick();
    ce = 1'b1;
    wait_done();
    chk("ce_stretch", out_cyc0 - acc_cyc, NST + 5);

    prev_n = n_out0;
    prev_v = longint'(oval0);
    prev_c = longint'(och0);
    send(5, 4321, 0, 1);
    repeat (5) tick();
    chk("bad_ch_no_valid", n_out0, prev_n);
    chk("bad_ch_value_held", longint'(oval0), prev_v);
    chk("bad_ch_channel_held", longint'(och0), prev_c);
    send(1, 1234, 0, 3);
    wait_done();
    chk("bad_ch_no_write", longint'(oval0), 1234);

    prev_n = n_out0;
    send(0, 1000, 0, 1);
    tick();
    do_reset();
    repeat (4) tick();
    chk("abort_no_valid", n_out0, prev_n);
    send(0, 1000, 0, 1);
    wait_done();
    chk("after_abort", longint'(oval0), 250);

    ce_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send($urandom_range(0, 7), int'($urandom_range(0, 65535)),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) tick();
    end
    ce_rand = 1'b0;
    ce = 1'b1;
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "global timeout");
  end

endmodule
